// File: rtl/bram_arbiter_if.sv
// Bundle of the two requester ports and the single-port RAM command/return
// signals shared by the BRAM arbiter and whatever drives it.
interface bram_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  // Port A requester
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_lock;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  // Port B requester
  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_lock;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  // Single-port RAM command and read return
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  // Arbiter side
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_lock,
    input  b_req, b_we, b_addr, b_wdata, b_lock,
    input  mem_dout,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_we, mem_addr, mem_din
  );

  // Requester / RAM side
  modport master (
    output a_req, a_we, a_addr, a_wdata, a_lock,
    output b_req, b_we, b_addr, b_wdata, b_lock,
    output mem_dout,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a single-port BRAM with one-cycle read latency.
// Grants are combinational in the request cycle; ties go round-robin, and a
// port may hold ownership across accesses with its lock input. Read returns
// are tagged to the port that issued them one cycle after the grant.
module bram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  bram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  owner_t                owner;
  owner_t                owner_next;
  logic                  last_a;       // 1: A was granted most recently
  logic                  last_a_next;
  logic                  gnt_a;
  logic                  gnt_b;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_din;
  logic                  rvalid_a_p1;
  logic                  rvalid_b_p1;

  // Ownership and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner  <= OWN_NONE;
      last_a <= 1'b0;
    end else begin
      owner  <= owner_next;
      last_a <= last_a_next;
    end
  end

  // Grant selection plus next owner/pointer; no grant is ever issued in reset
  always_comb begin
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    owner_next  = OWN_NONE;
    last_a_next = last_a;
    if (rst_n) begin
      if (owner == OWN_A && bus.a_req) begin
        gnt_a = 1'b1;
      end else if (owner == OWN_B && bus.b_req) begin
        gnt_b = 1'b1;
      end else if (bus.a_req && bus.b_req) begin
        // Owner absent or idle: the port not served last wins the tie
        if (last_a) gnt_b = 1'b1;
        else        gnt_a = 1'b1;
      end else if (bus.a_req) begin
        gnt_a = 1'b1;
      end else if (bus.b_req) begin
        gnt_b = 1'b1;
      end
    end
    // An idle cycle (no grant) always drops ownership, since an owner that
    // is still requesting is guaranteed the grant.
    if (gnt_a) begin
      last_a_next = 1'b1;
      owner_next  = bus.a_lock ? OWN_A : OWN_NONE;
    end else if (gnt_b) begin
      last_a_next = 1'b0;
      owner_next  = bus.b_lock ? OWN_B : OWN_NONE;
    end
  end

  // RAM command mux: the granted port drives the RAM, otherwise all zero
  always_comb begin
    cmd_we   = 1'b0;
    cmd_addr = '0;
    cmd_din  = '0;
    if (gnt_a) begin
      cmd_we   = bus.a_we;
      cmd_addr = bus.a_addr;
      cmd_din  = bus.a_wdata;
    end else if (gnt_b) begin
      cmd_we   = bus.b_we;
      cmd_addr = bus.b_addr;
      cmd_din  = bus.b_wdata;
    end
  end

  // Stage p0 -> p1: tag each granted read so its data is routed next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_a_p1 <= 1'b0;
      rvalid_b_p1 <= 1'b0;
    end else begin
      rvalid_a_p1 <= gnt_a & ~bus.a_we;
      rvalid_b_p1 <= gnt_b & ~bus.b_we;
    end
  end

  assign bus.a_gnt    = gnt_a;
  assign bus.b_gnt    = gnt_b;
  assign bus.mem_we   = cmd_we;
  assign bus.mem_addr = cmd_addr;
  assign bus.mem_din  = cmd_din;
  assign bus.a_rvalid = rvalid_a_p1;
  assign bus.b_rvalid = rvalid_b_p1;
  assign bus.a_rdata  = bus.mem_dout;
  assign bus.b_rdata  = bus.mem_dout;

endmodule

// File: tb/tb_bram_arbiter.sv
// Testbench for bram_arbiter: directed scenarios with literal expectations,
// followed by randomized traffic checked every cycle against a rule-level
// model of arbitration, ownership and RAM contents.
module tb_bram_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment RAM: synchronous single-port, one-cycle read latency
  logic [DW-1:0] ram [0:DEPTH-1];
  // Model's view of memory contents
  logic [DW-1:0] m_ram [0:DEPTH-1];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]   = DW'((i * 37 + 11) & 255);
      m_ram[i] = DW'((i * 37 + 11) & 255);
    end
  end

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr];
  end

  // ---------------- behavioural model ----------------
  // owner: 0 none, 1 A, 2 B; last: port granted most recently; rv: port
  // whose read data is due this cycle (0 none)
  int            m_owner = 0;
  int            m_last  = 2;
  int            m_rv    = 0;
  logic [DW-1:0] m_rv_data;
  bit            pend = 0;
  int            n_owner, n_last, n_rv;
  logic [DW-1:0] n_data;
  bit            n_wr;
  logic [AW-1:0] n_waddr;
  logic [DW-1:0] n_wdata;

  // Compare DUT outputs with the model mid-cycle and stage the model update
  always @(negedge clk) begin
    int            g;
    bit            e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    bit            e_lock;
    if (!rst_n) begin
      check("m_rst_a_gnt", bus.a_gnt, 0);
      check("m_rst_b_gnt", bus.b_gnt, 0);
      check("m_rst_mem_we", bus.mem_we, 0);
      check("m_rst_mem_addr", bus.mem_addr, 0);
      check("m_rst_mem_din", bus.mem_din, 0);
      check("m_rst_a_rvalid", bus.a_rvalid, 0);
      check("m_rst_b_rvalid", bus.b_rvalid, 0);
      pend = 0;
    end else begin
      g = 0;
      if (m_owner == 1 && bus.a_req)      g = 1;
      else if (m_owner == 2 && bus.b_req) g = 2;
      else if (bus.a_req && bus.b_req)    g = (m_last == 1) ? 2 : 1;
      else if (bus.a_req)                 g = 1;
      else if (bus.b_req)                 g = 2;
      e_we = 0; e_addr = '0; e_din = '0; e_lock = 0;
      if (g == 1) begin
        e_we = bus.a_we; e_addr = bus.a_addr; e_din = bus.a_wdata; e_lock = bus.a_lock;
      end else if (g == 2) begin
        e_we = bus.b_we; e_addr = bus.b_addr; e_din = bus.b_wdata; e_lock = bus.b_lock;
      end
      check("m_a_gnt", bus.a_gnt, (g == 1));
      check("m_b_gnt", bus.b_gnt, (g == 2));
      check("m_mem_we", bus.mem_we, e_we);
      check("m_mem_addr", bus.mem_addr, e_addr);
      check("m_mem_din", bus.mem_din, e_din);
      check("m_a_rvalid", bus.a_rvalid, (m_rv == 1));
      check("m_b_rvalid", bus.b_rvalid, (m_rv == 2));
      if (m_rv == 1) check("m_a_rdata", bus.a_rdata, m_rv_data);
      if (m_rv == 2) check("m_b_rdata", bus.b_rdata, m_rv_data);
      n_owner = (g != 0 && e_lock) ? g : 0;
      n_last  = (g != 0) ? g : m_last;
      n_rv    = (g != 0 && !e_we) ? g : 0;
      n_data  = m_ram[e_addr];
      n_wr    = (g != 0 && e_we);
      n_waddr = e_addr;
      n_wdata = e_din;
      pend    = 1;
    end
  end

  // Commit the staged model update on the clock edge
  always @(posedge clk) begin
    if (pend && rst_n) begin
      m_owner   = n_owner;
      m_last    = n_last;
      m_rv      = n_rv;
      m_rv_data = n_data;
      if (n_wr) m_ram[n_waddr] = n_wdata;
    end
    pend = 0;
  end

  // Asynchronous reset of the model
  always @(negedge rst_n) begin
    m_owner = 0;
    m_last  = 2;
    m_rv    = 0;
    pend    = 0;
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0; bus.a_lock = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0; bus.b_lock = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t, expected under 200000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    // Outputs held at reset values while reset is asserted
    @(negedge clk);
    check("rst_a_gnt", bus.a_gnt, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_a_rvalid", bus.a_rvalid, 0);
    step();
    rst_n = 1'b1;

    // Both reading each cycle: A,B,A,B and tagged returns one cycle later
    bus.a_req = 1; bus.b_req = 1; bus.a_addr = 10'd1; bus.b_addr = 10'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_a_gnt", bus.a_gnt, (i % 2 == 0));
      check("rr_b_gnt", bus.b_gnt, (i % 2 == 1));
      check("rr_a_rvalid", bus.a_rvalid, (i == 1 || i == 3));
      check("rr_b_rvalid", bus.b_rvalid, (i == 2));
      if (i == 1) check("rr_a_rdata", bus.a_rdata, 8'h30);
      step();
    end
    idle();
    @(negedge clk);
    check("rr_tail_a_rvalid", bus.a_rvalid, 0);
    check("rr_tail_b_rvalid", bus.b_rvalid, 1);
    check("rr_tail_b_rdata", bus.b_rdata, 8'h55);
    step();

    // Write 0x5A to address 3 then read it back on A
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 10'd3; bus.a_wdata = 8'h5A;
    @(negedge clk);
    check("wr_a_gnt", bus.a_gnt, 1);
    check("wr_mem_we", bus.mem_we, 1);
    check("wr_mem_addr", bus.mem_addr, 3);
    check("wr_mem_din", bus.mem_din, 8'h5A);
    step();
    bus.a_we = 0; bus.a_wdata = '0;
    @(negedge clk);
    check("wr_rd_a_gnt", bus.a_gnt, 1);
    check("wr_rd_no_rvalid", bus.a_rvalid, 0);
    step();
    idle();
    @(negedge clk);
    check("wr_rd_a_rvalid", bus.a_rvalid, 1);
    check("wr_rd_a_rdata", bus.a_rdata, 8'h5A);
    check("wr_rd_b_rvalid", bus.b_rvalid, 0);
    step();

    // Single B access so the next tie goes to A
    bus.b_req = 1; bus.b_addr = 10'd4;
    @(negedge clk);
    check("solo_b_gnt", bus.b_gnt, 1);
    step();

    // A locks for three accesses, releases on the fourth, then B is served
    bus.a_req = 1; bus.a_lock = 1; bus.a_addr = 10'd5;
    bus.b_req = 1; bus.b_addr = 10'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lock_a_gnt", bus.a_gnt, 1);
      check("lock_b_gnt", bus.b_gnt, 0);
      step();
    end
    bus.a_lock = 0;
    @(negedge clk);
    check("unlock_a_gnt", bus.a_gnt, 1);
    step();
    @(negedge clk);
    check("after_unlock_b_gnt", bus.b_gnt, 1);
    check("after_unlock_a_gnt", bus.a_gnt, 0);
    step();

    // Owner A drops its request: B granted in that same cycle
    idle();
    bus.a_req = 1; bus.a_lock = 1; bus.a_addr = 10'd8;
    @(negedge clk);
    check("own_a_gnt", bus.a_gnt, 1);
    step();
    bus.a_req = 0; bus.a_lock = 0; bus.b_req = 1; bus.b_addr = 10'd9;
    @(negedge clk);
    check("drop_b_gnt", bus.b_gnt, 1);
    check("drop_a_gnt", bus.a_gnt, 0);
    step();
    bus.a_req = 1;
    @(negedge clk);
    check("drop_then_tie_a_gnt", bus.a_gnt, 1);
    step();

    // Reset arrives between a read grant and its return
    idle();
    bus.a_req = 1; bus.a_addr = 10'd7;
    @(negedge clk);
    check("prerst_a_gnt", bus.a_gnt, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_a_gnt", bus.a_gnt, 0);
    check("midrst_mem_addr", bus.mem_addr, 0);
    check("midrst_a_rvalid", bus.a_rvalid, 0);
    step();
    @(negedge clk);
    check("inrst_a_rvalid", bus.a_rvalid, 0);
    step();
    rst_n = 1'b1;
    bus.b_req = 1; bus.b_addr = 10'd1;
    @(negedge clk);
    check("postrst_tie_a_gnt", bus.a_gnt, 1);
    check("postrst_tie_b_gnt", bus.b_gnt, 0);
    step();

    // Quiet bus for five cycles
    idle();
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("quiet_mem_we", bus.mem_we, 0);
      check("quiet_gnt", {bus.a_gnt, bus.b_gnt}, 0);
      check("quiet_rvalid", {bus.a_rvalid, bus.b_rvalid}, 0);
      step();
    end

    // Randomized traffic on a small address window, occasional async reset
    for (int c = 0; c < 3000; c++) begin
      bus.a_req   = ($urandom_range(0, 3) != 0);
      bus.a_we    = ($urandom_range(0, 2) == 0);
      bus.a_addr  = AW'($urandom_range(0, 15));
      bus.a_wdata = DW'($urandom);
      bus.a_lock  = ($urandom_range(0, 2) == 0);
      bus.b_req   = ($urandom_range(0, 3) != 0);
      bus.b_we    = ($urandom_range(0, 2) == 0);
      bus.b_addr  = AW'($urandom_range(0, 15));
      bus.b_wdata = DW'($urandom);
      bus.b_lock  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    idle();
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, tape/program address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, cell width.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports a_req, b_req  input  1 each  access request, held until granted.
REQ-006 The block SHALL have ports a_we, b_we  input  1 each  1 = write, 0 = read.
REQ-007 The block SHALL have ports a_addr, b_addr  input  ADDR_WIDTH each  access address.
REQ-008 The block SHALL have ports a_wdata, b_wdata  input  DATA_WIDTH each  write data.
REQ-009 The block SHALL have ports a_lock, b_lock  input  1 each  request to keep ownership after this access.
REQ-010 The block SHALL have ports a_gnt, b_gnt  output  1 each  access accepted this cycle.
REQ-011 The block SHALL have ports a_rvalid, b_rvalid  output  1 each  read data valid this cycle.
REQ-012 The block SHALL have ports a_rdata, b_rdata  output  DATA_WIDTH each  read return data.
REQ-013 The block SHALL have ports mem_we  output  1; mem_addr  output  ADDR_WIDTH; mem_din  output  DATA_WIDTH  single-port RAM command.
REQ-014 The block SHALL have port mem_dout  input  DATA_WIDTH  RAM read data, valid one cycle after address.

Function
REQ-015 Grant SHALL be combinational in the request cycle; the granted port's we/addr/wdata SHALL drive mem_we/mem_addr/mem_din in that same cycle.
REQ-016 At most one of a_gnt, b_gnt SHALL be high per cycle; no gnt without the matching req.
REQ-017 With no grant, mem_we SHALL be 0, mem_addr and mem_din SHALL be 0.
REQ-018 Single requester: it SHALL be granted immediately (subject to REQ-020).
REQ-019 Both requesting, no owner: round-robin; the port not granted most recently SHALL win; last-grant pointer updates on every grant.
REQ-020 Owner register (NONE/A/B): set to port P when P is granted with P_lock=1; cleared when owner is granted with lock=0 or owner's req is 0 in a cycle; while owner is set and its req=1, only owner SHALL be granted.
REQ-021 If owner's req is 0, the other port SHALL be granted in that same cycle if requesting (owner cleared at that edge).
REQ-022 A granted read SHALL assert that port's rvalid for exactly the following cycle; writes SHALL never assert rvalid.
REQ-023 a_rdata and b_rdata SHALL equal mem_dout; contents meaningful only while the matching rvalid=1.
REQ-024 Throughput SHALL be one access per cycle; back-to-back reads SHALL yield back-to-back rvalid, tagged to the correct port.
REQ-025 Write then read of same address on consecutive grants SHALL return the written data (one-cycle RAM latency, no bypass needed).

Reset
REQ-026 While rst_n=0: a_gnt=b_gnt=0, mem_we=0, mem_addr=0, mem_din=0, a_rvalid=b_rvalid=0, owner=NONE, last-grant=B (A wins first tie).
REQ-027 Reset asserted mid-operation SHALL clear pending rvalid and ownership immediately (asynchronous); RAM contents are not affected by the block.
REQ-028 First edge after rst_n rises SHALL behave as a normal arbitration cycle.

Verification
REQ-029 After reset, a_req=b_req=1, both reads, held 4 cycles -> grants A,B,A,B; rvalid A,B,A,B each one cycle later.
REQ-030 A writes 0x5A to addr 3, next cycle A reads addr 3 -> a_rvalid next cycle with a_rdata=0x5A; b_rvalid stays 0.
REQ-031 A granted with a_lock=1 for 3 accesses while b_req=1 -> a_gnt 3 consecutive cycles; A's 4th access with a_lock=0 granted, then B granted next cycle.
REQ-032 Owner A drops a_req while b_req=1 -> b_gnt same cycle; owner cleared.
REQ-033 Read granted, rst_n pulled low before next edge -> rvalid stays 0, all outputs at REQ-026 values; after release, tie goes to A.
REQ-034 No requests for 5 cycles -> mem_we=0, no gnt, no rvalid throughout.
